// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, sequencer states and opcode classification
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam logic [31:0] ADD = 32'd3;
   localparam logic [31:0] SUB = 32'd4;
   localparam logic [31:0] AND = 32'd5;
   localparam logic [31:0] OR  = 32'd6;
   localparam logic [31:0] SHR = 32'd7;
   localparam logic [31:0] SHL = 32'd8;
   localparam logic [31:0] ROR = 32'd9;
   localparam logic [31:0] ROL = 32'd10;
   localparam logic [31:0] MUL = 32'd14;
   localparam logic [31:0] DIV = 32'd15;
   localparam logic [31:0] NEG = 32'd16;
   localparam logic [31:0] NOT = 32'd17;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      T0    = 4'd1,
      T1    = 4'd2,
      T2    = 4'd3,
      T3    = 4'd4,
      T4    = 4'd5,
      T5    = 4'd6,
      T5U   = 4'd7,
      T6    = 4'd8,
      DONE  = 4'd9,
      FAULT = 4'd10
   } state_e;

   typedef enum logic [1:0] {
      BIN     = 2'd0,
      UNARY   = 2'd1,
      WIDE    = 2'd2,
      ILLEGAL = 2'd3
   } op_class_e;

   function automatic op_class_e op_class(input logic [31:0] opc);
      case (opc)
         ADD, SUB, AND, OR, SHR, SHL, ROR, ROL: op_class = BIN;
         MUL, DIV:                             op_class = WIDE;
         NEG, NOT:                             op_class = UNARY;
         default:                              op_class = ILLEGAL;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_instr_sequencer_onehot_dec.sv
// ============================================================================
// onehot_dec : binary index to one-hot vector with global enable
// Rev 1.0
// ============================================================================
`default_nettype none

module onehot_dec #(
   parameter int IN_W  = 4,
   parameter int OUT_N = 16
) (
   input  logic             en,
   input  logic [IN_W-1:0]  sel,
   output logic [OUT_N-1:0] onehot
);

   genvar i;
   generate
      for (i = 0; i < OUT_N; i++) begin : g_bit
         assign onehot[i] = en && (sel == IN_W'(i));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_instr_sequencer.sv
// ============================================================================
// alu_instr_sequencer : fetch/execute control-step FSM for register ALU ops
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_instr_sequencer
   import alu_seq_pkg::*;
#(
   parameter int               DATA_W      = 32,
   parameter int               NREG        = 16,
   parameter int               OPC_W       = 5,
   parameter logic [OPC_W-1:0] INC_OP      = 5'd12,
   parameter int               MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] ir,
   output logic              pc_out,
   output logic              zlow_out,
   output logic              zhigh_out,
   output logic              mdr_out,
   output logic              mar_in,
   output logic              pc_in,
   output logic              mdr_in,
   output logic              ir_in,
   output logic              y_in,
   output logic              z_in,
   output logic              hi_in,
   output logic              lo_in,
   output logic              read,
   output logic [OPC_W-1:0]  alu_op,
   output logic [NREG-1:0]   r_out,
   output logic [NREG-1:0]   r_in,
   output logic              busy,
   output logic              done,
   output logic              fault
);

   localparam int REG_W = $clog2(NREG);
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam int LOW_W = DATA_W - OPC_W - 3 * REG_W;

   state_e            state, state_nxt;
   logic [CNT_W-1:0]  tcnt;
   logic [OPC_W-1:0]  opc;
   logic [REG_W-1:0]  ra, rb, rc;
   op_class_e         cls;
   logic              rout_en, rin_en;
   logic [REG_W-1:0]  rout_sel, rin_sel;

   assign opc = ir[DATA_W-1 -: OPC_W];
   assign ra  = ir[DATA_W-OPC_W-1 -: REG_W];
   assign rb  = ir[DATA_W-OPC_W-REG_W-1 -: REG_W];
   assign rc  = ir[DATA_W-OPC_W-2*REG_W-1 -: REG_W];
   assign cls = op_class(32'(opc));

   generate
      if (LOW_W > 0) begin : g_unused_ir
         logic unused_ir_bits;
         assign unused_ir_bits = ^ir[LOW_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == T0)
            tcnt <= '0;
         else if (state == T1 && !mem_ready)
            tcnt <= tcnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = T0;
         T0:    state_nxt = T1;
         T1: begin
            if (mem_ready)
               state_nxt = T2;
            else if (tcnt == CNT_W'(MEM_TIMEOUT - 1))
               state_nxt = FAULT;
         end
         T2:    state_nxt = T3;
         T3: begin
            case (cls)
               BIN, WIDE: state_nxt = T4;
               UNARY:     state_nxt = T5U;
               default:   state_nxt = FAULT;
            endcase
         end
         T4:    state_nxt = T5;
         T5:    state_nxt = (cls == WIDE) ? T6 : DONE;
         T5U:   state_nxt = DONE;
         T6:    state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         FAULT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pc_out    = 1'b0;
      zlow_out  = 1'b0;
      zhigh_out = 1'b0;
      mdr_out   = 1'b0;
      mar_in    = 1'b0;
      pc_in     = 1'b0;
      mdr_in    = 1'b0;
      ir_in     = 1'b0;
      y_in      = 1'b0;
      z_in      = 1'b0;
      hi_in     = 1'b0;
      lo_in     = 1'b0;
      read      = 1'b0;
      alu_op    = '0;
      busy      = (state != IDLE);
      done      = 1'b0;
      fault     = 1'b0;
      rout_en   = 1'b0;
      rout_sel  = '0;
      rin_en    = 1'b0;
      rin_sel   = '0;
      case (state)
         T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            z_in   = 1'b1;
            alu_op = INC_OP;
         end
         T1: begin
            // The incremented PC is written back only once, on the first wait cycle
            zlow_out = (tcnt == '0);
            pc_in    = (tcnt == '0);
            read     = 1'b1;
            mdr_in   = 1'b1;
         end
         T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         T3: begin
            if (cls != ILLEGAL) begin
               rout_en  = 1'b1;
               rout_sel = rb;
            end
            if (cls == BIN || cls == WIDE)
               y_in = 1'b1;
            if (cls == UNARY) begin
               alu_op = opc;
               z_in   = 1'b1;
            end
         end
         T4: begin
            rout_en  = 1'b1;
            rout_sel = rc;
            alu_op   = opc;
            z_in     = 1'b1;
         end
         T5: begin
            zlow_out = 1'b1;
            if (cls == WIDE) begin
               lo_in = 1'b1;
            end else begin
               rin_en  = 1'b1;
               rin_sel = ra;
            end
         end
         T5U: begin
            zlow_out = 1'b1;
            rin_en   = 1'b1;
            rin_sel  = ra;
         end
         T6: begin
            zhigh_out = 1'b1;
            hi_in     = 1'b1;
         end
         DONE:  done  = 1'b1;
         FAULT: fault = 1'b1;
         default: ;
      endcase
   end

   onehot_dec #(.IN_W(REG_W), .OUT_N(NREG)) u_rout_dec (
      .en     (rout_en),
      .sel    (rout_sel),
      .onehot (r_out)
   );

   onehot_dec #(.IN_W(REG_W), .OUT_N(NREG)) u_rin_dec (
      .en     (rin_en),
      .sel    (rin_sel),
      .onehot (r_in)
   );

   a_single_bus_driver : assert property (@(posedge clk) disable iff (clr)
      $countones({r_out, pc_out, zlow_out, zhigh_out, mdr_out}) <= 1);

endmodule

`default_nettype wire
